// File: rtl/stream_pkg.sv
// rtl/stream_pkg.sv - shared types and helpers for the stream multiplexer (see STREAM_MUX_RR_EN in stream_mux.sv)
package stream_pkg;

    typedef enum logic {
        MODE_SEL = 1'b0,
        MODE_RR  = 1'b1
    } mux_mode_e;

    // Width of a channel-index field for n channels; never narrower than one bit.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter: first requester at or after ptr, wrapping
module rr_arbiter
    import stream_pkg::*;
#(
    parameter int N     = 4,
    parameter int SEL_W = sel_width(N)
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    input  logic             advance,
    output logic [N-1:0]     gnt,
    output logic [SEL_W-1:0] gnt_idx,
    output logic [SEL_W-1:0] next_ptr
);

    int best;
    int best_off;
    int off;

    // Pick the requester with the smallest distance from ptr, counting upward with wrap.
    always_comb begin
        gnt      = '0;
        gnt_idx  = '0;
        best     = 0;
        best_off = N;
        off      = 0;
        for (int i = 0; i < N; i++) begin
            off = (i >= int'(ptr)) ? (i - int'(ptr)) : (i + N - int'(ptr));
            if (req[i] && (off < best_off)) begin
                best_off = off;
                best     = i;
                gnt      = '0;
                gnt[i]   = 1'b1;
                gnt_idx  = SEL_W'(i);
            end
        end
    end

    // Pointer moves just past the granted channel only when a transfer actually happens.
    always_comb begin
        next_ptr = ptr;
        if (advance) begin
            next_ptr = (int'(gnt_idx) == N - 1) ? '0 : gnt_idx + 1'b1;
        end
    end

endmodule

// File: rtl/stream_mux.sv
// rtl/stream_mux.sv - N-way valid/ready stream mux with registered output; STREAM_MUX_RR_EN adds round-robin
module stream_mux
    import stream_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    parameter int SEL_W = sel_width(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               mode,
    input  logic [SEL_W-1:0]   sel,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    input  logic [N*WIDTH-1:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [SEL_W-1:0]   out_chan
);

    logic             can_load;
    logic [N-1:0]     sel_gnt;
    logic [N-1:0]     grant;
    logic             xfer;
    logic [WIDTH-1:0] load_data;
    logic [SEL_W-1:0] load_chan;

    assign can_load = !out_valid || out_ready;

    // Explicit select: an out-of-range sel matches no channel, so nothing is granted.
    always_comb begin
        sel_gnt = '0;
        for (int i = 0; i < N; i++) begin
            if (sel == SEL_W'(i)) begin
                sel_gnt[i] = in_valid[i];
            end
        end
    end

`ifdef STREAM_MUX_RR_EN
    logic             use_rr;
    logic [SEL_W-1:0] rr_ptr;
    logic [SEL_W-1:0] rr_next;
    logic [N-1:0]     rr_gnt;
    logic [SEL_W-1:0] rr_idx;

    assign use_rr = (mux_mode_e'(mode) == MODE_RR);

    rr_arbiter #(
        .N     (N),
        .SEL_W (SEL_W)
    ) u_rr_arbiter (
        .req      (in_valid),
        .ptr      (rr_ptr),
        .advance  (use_rr && xfer),
        .gnt      (rr_gnt),
        .gnt_idx  (rr_idx),
        .next_ptr (rr_next)
    );

    assign grant     = use_rr ? rr_gnt : sel_gnt;
    assign load_chan = use_rr ? rr_idx : sel;

    // Round-robin pointer; only mode-1 transfers move it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else begin
            rr_ptr <= rr_next;
        end
    end
`else
    logic unused_mode;

    assign unused_mode = mode;
    assign grant       = sel_gnt;
    assign load_chan   = sel;
`endif

    assign in_ready = grant & {N{can_load}};
    assign xfer     = |(in_valid & in_ready);

    // Data of the (one-hot) granted channel.
    always_comb begin
        load_data = '0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                load_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Output register: a load replaces any draining word; otherwise drain empties it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= load_data;
            out_chan  <= load_chan;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_stream_mux.sv
// tb/tb_stream_mux.sv - scoreboard bench for stream_mux
module tb_stream_mux;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mode;
    logic [1:0]  sel;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [127:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [1:0]  out_chan;

    logic [1:0]  sel3;
    logic [2:0]  in_valid3;
    logic [2:0]  in_ready3;
    logic [23:0] in_data3;
    logic        out_valid3;
    logic        out_ready3;
    logic [7:0]  out_data3;
    logic [1:0]  out_chan3;

    int checks   = 0;
    int failures = 0;
    logic [33:0] exp_q[$];

    always #5 clk = ~clk;

    stream_mux #(.WIDTH(32), .N(4)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .sel       (sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_chan  (out_chan)
    );

    stream_mux #(.WIDTH(8), .N(3)) u_dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (1'b0),
        .sel       (sel3),
        .in_valid  (in_valid3),
        .in_ready  (in_ready3),
        .in_data   (in_data3),
        .out_valid (out_valid3),
        .out_ready (out_ready3),
        .out_data  (out_data3),
        .out_chan  (out_chan3)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input logic [31:0] base);
        for (int i = 0; i < 4; i++) in_data[i*32 +: 32] = base + 32'(i);
    endtask

    task automatic push(input int ch, input logic [31:0] base);
        exp_q.push_back({2'(ch), base + 32'(ch)});
    endtask

    // Monitor: every output handshake must match the oldest expected word.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected actual chan=%0d data=%0h expected none", out_chan, out_data);
            end else begin
                logic [33:0] e;
                e = exp_q.pop_front();
                if ({out_chan, out_data} !== e) begin
                    failures++;
                    $display("FAIL sb_word actual chan=%0d data=%0h expected chan=%0d data=%0h",
                             out_chan, out_data, e[33:32], e[31:0]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; mode = 1'b0; sel = 2'd0; in_valid = 4'b0; in_data = '0; out_ready = 1'b0;
        sel3 = 2'd0; in_valid3 = 3'b0; in_data3 = 24'h332211; out_ready3 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_data", out_data, 0);
        chk("reset_out_chan", out_chan, 0);
        chk("reset_in_ready", in_ready, 0);
        cyc();
        rst_n = 1'b1;

        // Out-of-range select on a 3-channel instance.
        sel3 = 2'd3; in_valid3 = 3'b111; out_ready3 = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("oor_in_ready", in_ready3, 0);
            chk("oor_out_valid", out_valid3, 0);
            cyc();
        end
        sel3 = 2'd2;
        @(negedge clk);
        chk("n3_sel2_in_ready", in_ready3, 3'b100);
        cyc();
        in_valid3 = 3'b000;
        @(negedge clk);
        chk("n3_out_valid", out_valid3, 1);
        chk("n3_out_chan", out_chan3, 2);
        chk("n3_out_data", out_data3, 8'h33);
        cyc();

        // Explicit select, sel = 2, channels 0..2 valid.
        set_data(32'hA000_0000);
        mode = 1'b0; sel = 2'd2; in_valid = 4'b0111; out_ready = 1'b1;
        push(2, 32'hA000_0000);
        @(negedge clk);
        chk("sel2_in_ready", in_ready, 4'b0100);
        cyc();
        in_valid = 4'b0000;
        @(negedge clk);
        cyc();

        // Backpressure: load, hold 3 cycles, then drain and reload in one cycle.
        set_data(32'hB100_0000);
        sel = 2'd1; in_valid = 4'b0010; out_ready = 1'b1;
        push(1, 32'hB100_0000);
        cyc();
        set_data(32'hB200_0000);
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_out_data", out_data, 32'hB100_0001);
            chk("bp_out_chan", out_chan, 1);
            chk("bp_in_ready", in_ready, 0);
            cyc();
        end
        out_ready = 1'b1;
        push(1, 32'hB200_0000);
        @(negedge clk);
        chk("bp_release_in_ready", in_ready, 4'b0010);
        cyc();
        in_valid = 4'b0000;
        @(negedge clk);
        chk("bp_no_bubble", out_valid, 1);
        cyc();

`ifdef STREAM_MUX_RR_EN
        // Round-robin with every channel valid.
        set_data(32'hC000_0000);
        mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            push(k % 4, 32'hC000_0000);
            @(negedge clk);
            chk("rr_in_ready", in_ready, 4'(1 << (k % 4)));
            if (k > 0) chk("rr_out_valid", out_valid, 1);
            cyc();
        end
        in_valid = 4'b0000;
        @(negedge clk);
        cyc();

        // Round-robin skip: move ptr to 1, then only channels 0 and 3 request.
        set_data(32'hD000_0000);
        in_valid = 4'b0001;
        push(0, 32'hD000_0000);
        @(negedge clk);
        chk("rrskip_prime", in_ready, 4'b0001);
        cyc();
        in_valid = 4'b1001;
        push(3, 32'hD000_0000);
        @(negedge clk);
        chk("rrskip_first", in_ready, 4'b1000);
        cyc();
        push(0, 32'hD000_0000);
        @(negedge clk);
        chk("rrskip_second", in_ready, 4'b0001);
        cyc();
        in_valid = 4'b0000;
        @(negedge clk);
        cyc();
`else
        // Without round-robin, mode = 1 still follows sel.
        set_data(32'hE000_0000);
        mode = 1'b1; sel = 2'd3; in_valid = 4'b1111; out_ready = 1'b1;
        push(3, 32'hE000_0000);
        @(negedge clk);
        chk("norr_sel3", in_ready, 4'b1000);
        cyc();
        sel = 2'd0;
        push(0, 32'hE000_0000);
        @(negedge clk);
        chk("norr_sel0", in_ready, 4'b0001);
        cyc();
        in_valid = 4'b0000;
        @(negedge clk);
        cyc();
`endif

        // Reset mid-stream while a word is held.
        set_data(32'hF000_0000);
        mode = 1'b0; sel = 2'd2; in_valid = 4'b0100; out_ready = 1'b0;
        cyc();
        in_valid = 4'b0000;
        @(negedge clk);
        chk("mid_loaded", out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_out_data", out_data, 0);
        chk("mid_rst_out_chan", out_chan, 0);
        cyc();
        rst_n = 1'b1;
        set_data(32'h1234_0000);
        mode = 1'b1; sel = 2'd1; in_valid = 4'b1111; out_ready = 1'b1;
`ifdef STREAM_MUX_RR_EN
        push(0, 32'h1234_0000);
        @(negedge clk);
        chk("post_rst_rr_first", in_ready, 4'b0001);
`else
        push(1, 32'h1234_0000);
        @(negedge clk);
        chk("post_rst_sel_first", in_ready, 4'b0010);
`endif
        cyc();
        in_valid = 4'b0000;

        for (int t = 0; t < 20 && exp_q.size() != 0; t++) @(posedge clk);
        @(negedge clk);
        chk("sb_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/stream_mux.md
# stream_mux

Parametrised N-way, WIDTH-bit multiplexer for valid/ready streams, with a one-entry registered output stage. Each input channel has its own handshake. The block selects either an explicitly chosen channel or, in round-robin mode, the next requesting channel. It sits between pipeline producers, such as writeback sources and memory-response paths, and a single consumer. It replaces ad-hoc combinational muxes wherever backpressure and a registered output are needed.

## Interface
- `WIDTH`, 32, data width per channel
- `N`, 4, channel count; N ≥ 2
- `SEL_W`, `$clog2(N)`, width of select and channel-index fields
- `clk`  in  1  clock; all state updates on the rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `mode`  in  1  0 = explicit select, 1 = round-robin; sampled every cycle
- `sel`  in  SEL_W  channel index used when mode = 0
- `in_valid`  in  N  per-channel valid
- `in_ready`  out  N  per-channel ready; combinational
- `in_data`  in  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- `out_valid`  out  1  output register holds data
- `out_ready`  in  1  consumer accepts the data
- `out_data`  out  WIDTH  registered data
- `out_chan`  out  SEL_W  index of the channel that produced `out_data`

## Operation
- Output register state is {`out_valid`, `out_data`, `out_chan`}.
  - `can_load` = !out_valid | out_ready.
- `grant` is one-hot or zero, computed combinationally.
  - mode 0: grant[sel] = in_valid[sel]. If sel ≥ N, grant is 0, so no channel is accepted. This replaces the old undefined/Z default.
  - mode 1: the first i with in_valid[i], scanning from `rr_ptr` upward and wrapping from N-1 to 0.
- in_ready[i] = grant[i] & can_load. A non-granted channel always sees ready = 0.
- Transfer: when in_valid[i] & in_ready[i], at the edge:
  - out_data ← channel i data
  - out_chan ← i
  - out_valid ← 1
- Drain without refill: out_valid & out_ready & no grant → out_valid ← 0.
- Simultaneous drain and load in the same cycle: the new word replaces the old one. There is no bubble, so full throughput is 1 word/cycle.
- `rr_ptr` is SEL_W bits.
  - After any mode-1 transfer from channel i: rr_ptr ← (i == N-1) ? 0 : i+1.
  - Unchanged otherwise, including during mode-0 transfers.
- While out_valid = 1 and out_ready = 0:
  - out_data and out_chan hold stable.
  - All in_ready are 0.
- Inputs must follow AXI-style rules: valid is not withdrawn before ready, and data is stable while valid.

## Timing
- Reset values: out_valid = 0, out_data = 0, out_chan = 0, rr_ptr = 0. in_ready is therefore 0 for every channel without a valid grant.
- Reset asserted mid-operation immediately clears out_valid, and the held word is lost. On deassertion, the first transfer occurs at the first edge where a granted channel is valid.
- Latency: input handshake at edge k → out_valid = 1 and data visible after edge k.
- Input-to-output combinational paths:
  - in_valid/sel/mode → in_ready (through grant)
  - out_ready → in_ready
- There is no combinational path from any input to out_valid or out_data.
- Changing `mode` or `sel` takes effect in the same cycle's grant. An already-registered word is unaffected.

## Configuration
- `STREAM_MUX_RR_EN` defined:
  - Round-robin logic and `rr_ptr` are compiled in.
  - mode = 1 behaves as above.
- Not defined:
  - `mode` is ignored and the block is always in explicit-select mode.
  - `rr_ptr` and the arbiter are absent.
  - The port list is unchanged.

## Structure
- Shared package `stream_pkg`:
  - `mux_mode_e` (MODE_SEL = 0, MODE_RR = 1)
  - helper constant for SEL_W computation
- Sub-module `rr_arbiter`:
  - parameter N
  - inputs: req[N], ptr, advance
  - outputs: one-hot gnt, gnt_idx
  - Instantiated only under `STREAM_MUX_RR_EN`.

## Test plan
- **Select mode, sel = 2:** in_valid = 4'b0111, out_ready = 1 → only in_ready[2] = 1. The next cycle shows out_data = channel 2 data, out_chan = 2.
- **Select out of range:** N = 3, sel = 3, all valid → in_ready = 0 and out_valid stays 0.
- **Round-robin, all four channels continuously valid, out_ready = 1:** out_chan sequence 0,1,2,3,0,… with out_valid = 1 on every cycle after the first.
- **Backpressure:** after a load, hold out_ready = 0 for 3 cycles → out_data and out_chan are stable and all in_ready = 0. On out_ready = 1, drain and reload happen in the same cycle.
- **Round-robin skip:** rr_ptr = 1, only channels 0 and 3 valid → channel 3 is granted first, then channel 0.
- **Reset mid-stream:** with out_valid = 1, pulse rst_n low → out_valid = 0, out_data = 0 and rr_ptr = 0 immediately. After release, the first round-robin grant goes to channel 0.
